sirv_debug_entry_ctrl: RTL and testbench
========================================

Name: sirv_debug_entry_ctrl

Overview:
- Commit-side debug entry/exit controller; sits directly upstream of the debug CSR block.
- Decides when the core enters Debug Mode (ebreak, halt request, single-step) and when it leaves (dret).
- Produces the DPC/DCAUSE update strobes the CSR block consumes, and issues a pipeline flush to the debug vector or to DPC through a req/ack handshake.

Parameters:
- PC_SIZE, 32, width of PC values.
- DEBUG_ENTRY_PC, 32'h0000_0800, debug ROM entry vector (low PC_SIZE bits used).

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-high
- i_cmt_valid  input  1  an instruction is at commit this cycle
- i_cmt_pc  input  PC_SIZE  PC of committing instruction
- i_cmt_npc  input  PC_SIZE  next PC after committing instruction
- i_cmt_ebreak  input  1  committing instruction is ebreak
- i_cmt_dret  input  1  committing instruction is dret
- i_cmt_priv  input  2  current privilege (0=U, 1=S, 3=M)
- dbg_irq_r  input  1  halt request from Debug Module
- dbg_mode  input  1  from CSR block (dcause!=0)
- dbg_step_r, dbg_ebreakm_r, dbg_ebreaks_r, dbg_ebreaku_r  input  1 each  dcsr fields
- dpc_r  input  PC_SIZE  current DPC
- o_cmt_kill  output  1  combinational; suppress retirement of the committing instruction
- o_cmt_block  output  1  registered; commit stage must present no valid instruction
- cmt_dpc  output  PC_SIZE  DPC write value
- cmt_dpc_ena  output  1  DPC write strobe
- cmt_dcause  output  3  DCAUSE write value
- cmt_dcause_ena  output  1  DCAUSE write strobe
- o_flush_req  output  1  flush request
- o_flush_pc  output  PC_SIZE  flush target
- i_flush_ack  input  1  flush accepted

Behaviour:
- Clocking: one clock, clk; rst is synchronous and active-high.
- Reset: state RUN; all registered outputs 0; cmt_dcause=0.
- DCAUSE encoding: 1 ebreak, 3 haltreq, 4 step, 5 resethaltreq; 0 means exit debug.
- States: RUN, ENTER_WAIT, DEBUG, EXIT_WAIT.
- Decision is made in cycle T. At T+1:
  - cmt_dpc_ena and cmt_dcause_ena pulse for exactly one cycle.
  - o_flush_req rises, with o_flush_pc stable until the handshake completes.
- Handshake completes on the first cycle with o_flush_req & i_flush_ack. o_flush_req drops the following cycle.
- o_cmt_block=1 in ENTER_WAIT and EXIT_WAIT.
- RUN, on i_cmt_valid, priority ebreak > haltreq > step:
  - ebreak entry: i_cmt_ebreak with the enable matching i_cmt_priv (M: ebreakm, S: ebreaks, U: ebreaku) -> o_cmt_kill=1, dpc=i_cmt_pc, cause 1.
  - haltreq entry: dbg_irq_r -> o_cmt_kill=1, dpc=i_cmt_pc, cause 3.
  - step entry: dbg_step_r -> instruction retires (kill=0), dpc=i_cmt_npc, cause 4.
  - Any entry: -> ENTER_WAIT, o_flush_pc=DEBUG_ENTRY_PC.
  - ebreak with its enable clear: no action (trap handled elsewhere).
  - dbg_irq_r with no valid commit: held off until the next valid commit, so DPC is always precise.
  - dret in RUN: ignored.
- ENTER_WAIT -> DEBUG on ack.
- DEBUG:
  - haltreq and step ignored.
  - ebreak -> o_cmt_kill=1; flush to DEBUG_ENTRY_PC via ENTER_WAIT; no DPC/DCAUSE write.
  - dret -> dcause write 0 (clears dbg_mode); flush to dpc_r sampled at T; -> EXIT_WAIT.
- EXIT_WAIT -> RUN on ack. If dbg_step_r=1, exactly one instruction then retires before step entry.
- Ack asserted while o_flush_req=0: ignored.
- Reset mid-handshake: flush request drops next cycle, state RUN, no strobes.

Optional Feature:
- Macro: SIRV_DBG_RESETHALT_EN.
- Defined:
  - Adds input i_resethaltreq (1 bit), sampled on the first cycle after rst deasserts.
  - If 1: enter debug before any instruction commits, with dpc=i_cmt_pc of the first valid commit (killed) and cause 5.
  - Until that entry, o_cmt_block=0 and haltreq priority applies.
- Undefined: port absent; cause 5 never produced.

Test Plan:
- RUN, priv=3, ebreakm=1, commit ebreak at pc 0x100 -> kill=1 at T; at T+1 cmt_dpc=0x100, cmt_dcause=1 strobes one cycle, flush_req with pc 0x800; ack 3 cycles later -> DEBUG, block drops next cycle.
- dbg_irq_r=1 with no valid commit for 5 cycles, then commit pc 0x204 -> no strobes until that commit; dpc=0x204, cause 3, kill=1.
- step=1, commit pc 0x300, npc 0x304 -> kill=0, dpc=0x304, cause 4.
- Same cycle ebreak (enabled) + haltreq + step at pc 0x400 -> cause 1, dpc=0x400.
- DEBUG, dpc_r=0x304, commit dret -> dcause write 0, flush_pc=0x304; ack -> RUN; with step=1 next commit (pc 0x304, npc 0x308) -> re-entry, dpc=0x308.
- Assert rst during ENTER_WAIT before ack -> flush_req=0, state RUN, no strobes; later ack ignored.

Source files
------------

// File: rtl/sirv_debug_entry_ctrl.sv
// sirv_debug_entry_ctrl: commit-side debug mode entry/exit with DPC/DCAUSE strobes and flush handshake; optional reset-halt via SIRV_DBG_RESETHALT_EN
module sirv_debug_entry_ctrl #(
  parameter int          PC_SIZE        = 32,
  parameter logic [31:0] DEBUG_ENTRY_PC = 32'h0000_0800
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SIRV_DBG_RESETHALT_EN
  input  logic               i_resethaltreq,
`endif
  input  logic               i_cmt_valid,
  input  logic [PC_SIZE-1:0] i_cmt_pc,
  input  logic [PC_SIZE-1:0] i_cmt_npc,
  input  logic               i_cmt_ebreak,
  input  logic               i_cmt_dret,
  input  logic [1:0]         i_cmt_priv,
  input  logic               dbg_irq_r,
  input  logic               dbg_mode,
  input  logic               dbg_step_r,
  input  logic               dbg_ebreakm_r,
  input  logic               dbg_ebreaks_r,
  input  logic               dbg_ebreaku_r,
  input  logic [PC_SIZE-1:0] dpc_r,
  output logic               o_cmt_kill,
  output logic               o_cmt_block,
  output logic [PC_SIZE-1:0] cmt_dpc,
  output logic               cmt_dpc_ena,
  output logic [2:0]         cmt_dcause,
  output logic               cmt_dcause_ena,
  output logic               o_flush_req,
  output logic [PC_SIZE-1:0] o_flush_pc,
  input  logic               i_flush_ack
);
  localparam logic [PC_SIZE-1:0] ENTRY_PC = PC_SIZE'(DEBUG_ENTRY_PC);
  typedef enum logic [1:0] {RUN, ENTER_WAIT, DEBUG, EXIT_WAIT} state_t;
  state_t state, nxt;
  logic ebk_en, run_ok, run_ebk, run_halt, run_step, run_entry, dbg_ebk, dbg_dret, ack, rh_now;
  logic [2:0] entry_cause;
`ifdef SIRV_DBG_RESETHALT_EN
  logic first, rh_pend;
  assign rh_now = first ? i_resethaltreq : rh_pend;
  always_ff @(posedge clk) begin
    if (rst) begin
      first   <= 1'b1;
      rh_pend <= 1'b0;
    end else begin
      first   <= 1'b0;
      rh_pend <= rh_now & !run_entry;
    end
  end
`else
  assign rh_now = 1'b0;
`endif
  always_comb begin
    ebk_en      = i_cmt_priv == 2'd3 ? dbg_ebreakm_r :
                  i_cmt_priv == 2'd1 ? dbg_ebreaks_r :
                  i_cmt_priv == 2'd0 ? dbg_ebreaku_r : 1'b0;
    run_ok      = state == RUN & i_cmt_valid & !dbg_mode;
    run_ebk     = run_ok & i_cmt_ebreak & ebk_en;
    run_halt    = run_ok & !run_ebk & (dbg_irq_r | rh_now);
    run_step    = run_ok & !run_ebk & !run_halt & dbg_step_r;
    run_entry   = run_ebk | run_halt | run_step;
    entry_cause = run_ebk ? 3'd1 : run_halt ? (rh_now ? 3'd5 : 3'd3) : 3'd4;
    dbg_ebk     = state == DEBUG & i_cmt_valid & i_cmt_ebreak;
    dbg_dret    = state == DEBUG & i_cmt_valid & i_cmt_dret & !i_cmt_ebreak;
    o_cmt_kill  = run_ebk | run_halt | dbg_ebk;
    ack         = o_flush_req & i_flush_ack;
    nxt         = (run_entry | dbg_ebk) ? ENTER_WAIT :
                  dbg_dret ? EXIT_WAIT :
                  !ack ? state :
                  state == ENTER_WAIT ? DEBUG :
                  state == EXIT_WAIT ? RUN : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      o_cmt_block    <= 1'b0;
      cmt_dpc        <= '0;
      cmt_dpc_ena    <= 1'b0;
      cmt_dcause     <= 3'd0;
      cmt_dcause_ena <= 1'b0;
      o_flush_req    <= 1'b0;
      o_flush_pc     <= '0;
    end else begin
      state          <= nxt;
      o_cmt_block    <= nxt == ENTER_WAIT | nxt == EXIT_WAIT;
      cmt_dpc_ena    <= run_entry;
      cmt_dcause_ena <= run_entry | dbg_dret;
      if (run_entry) begin
        cmt_dpc    <= run_step ? i_cmt_npc : i_cmt_pc;
        cmt_dcause <= entry_cause;
      end else if (dbg_dret)
        cmt_dcause <= 3'd0;
      if (ack)
        o_flush_req <= 1'b0;
      else if (run_entry | dbg_ebk | dbg_dret) begin
        o_flush_req <= 1'b1;
        o_flush_pc  <= dbg_dret ? dpc_r : ENTRY_PC;
      end
    end
  end
endmodule

// File: tb/tb_sirv_debug_entry_ctrl.sv
// tb_sirv_debug_entry_ctrl: directed checks of debug entry/exit, strobes and flush handshake
module tb_sirv_debug_entry_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 0, ebreak = 0, dret = 0, irq = 0, dmode = 0, step = 0;
  logic ebm = 0, ebs = 0, ebu = 0, ack = 0;
  logic [1:0] priv = 2'd3;
  logic [31:0] pc = 0, npc = 0, dpc_r = 0;
  logic kill, block, dpc_ena, dcause_ena, flush_req;
  logic [31:0] dpc, flush_pc;
  logic [2:0] dcause;
  wire [6:0] ctl = {dpc_ena, dcause_ena, dcause, flush_req, block};
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sirv_debug_entry_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef SIRV_DBG_RESETHALT_EN
    .i_resethaltreq(1'b0),
`endif
    .i_cmt_valid(valid), .i_cmt_pc(pc), .i_cmt_npc(npc),
    .i_cmt_ebreak(ebreak), .i_cmt_dret(dret), .i_cmt_priv(priv),
    .dbg_irq_r(irq), .dbg_mode(dmode), .dbg_step_r(step),
    .dbg_ebreakm_r(ebm), .dbg_ebreaks_r(ebs), .dbg_ebreaku_r(ebu),
    .dpc_r(dpc_r), .o_cmt_kill(kill), .o_cmt_block(block),
    .cmt_dpc(dpc), .cmt_dpc_ena(dpc_ena), .cmt_dcause(dcause), .cmt_dcause_ena(dcause_ena),
    .o_flush_req(flush_req), .o_flush_pc(flush_pc), .i_flush_ack(ack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    valid = 0; ebreak = 0; dret = 0; irq = 0; step = 0; ack = 0; dmode = 0;
    ebm = 0; ebs = 0; ebu = 0; priv = 2'd3;
  endtask

  task automatic do_reset;
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (ctl !== 7'b0 || dpc !== 32'h0 || flush_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset: ctl=%b dpc=%h fpc=%h want 0", ctl, dpc, flush_pc);
    end
    ack = 1;
    tick();
    ack = 0;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL stray_ack: ctl=%b want 0000000", ctl);
    end
  endtask

  task automatic test_ebreak;
    do_reset();
    ebm = 1; valid = 1; ebreak = 1; pc = 32'h100; npc = 32'h104;
    #1;
    checks++;
    if (kill !== 1'b1) begin
      errors++;
      $display("FAIL ebreak_kill: got %b want 1", kill);
    end
    tick();
    valid = 0; ebreak = 0;
    checks++;
    if (ctl !== 7'b11_001_11 || dpc !== 32'h100 || flush_pc !== 32'h800) begin
      errors++;
      $display("FAIL ebreak_entry: ctl=%b dpc=%h fpc=%h want 1100111/100/800", ctl, dpc, flush_pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ctl !== 7'b00_001_11 || flush_pc !== 32'h800) begin
        errors++;
        $display("FAIL ebreak_hold%0d: ctl=%b fpc=%h want 0000111/800", i, ctl, flush_pc);
      end
    end
    ack = 1;
    tick();
    ack = 0;
    checks++;
    if (ctl !== 7'b00_001_00) begin
      errors++;
      $display("FAIL ebreak_ack: ctl=%b want 0000100", ctl);
    end
    dmode = 1; valid = 1; ebreak = 1; pc = 32'h120;
    #1;
    checks++;
    if (kill !== 1'b1) begin
      errors++;
      $display("FAIL dbg_ebreak_kill: got %b want 1", kill);
    end
    tick();
    valid = 0; ebreak = 0;
    checks++;
    if (ctl !== 7'b00_001_11 || dpc !== 32'h100 || flush_pc !== 32'h800) begin
      errors++;
      $display("FAIL dbg_ebreak: ctl=%b dpc=%h fpc=%h want 0000111/100/800", ctl, dpc, flush_pc);
    end
  endtask

  task automatic test_ebreak_disabled;
    do_reset();
    priv = 2'd1; ebm = 1; ebu = 1; valid = 1; ebreak = 1; pc = 32'h500;
    #1;
    checks++;
    if (kill !== 1'b0) begin
      errors++;
      $display("FAIL ebreak_s_off_kill: got %b want 0", kill);
    end
    tick();
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL ebreak_s_off: ctl=%b want 0000000", ctl);
    end
    priv = 2'd0; pc = 32'h510;
    tick();
    valid = 0; ebreak = 0;
    checks++;
    if (ctl !== 7'b11_001_11 || dpc !== 32'h510) begin
      errors++;
      $display("FAIL ebreak_u_on: ctl=%b dpc=%h want 1100111/510", ctl, dpc);
    end
  endtask

  task automatic test_haltreq;
    do_reset();
    irq = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ctl !== 7'b0) begin
        errors++;
        $display("FAIL halt_hold%0d: ctl=%b want 0000000", i, ctl);
      end
    end
    valid = 1; pc = 32'h204; npc = 32'h208;
    #1;
    checks++;
    if (kill !== 1'b1) begin
      errors++;
      $display("FAIL halt_kill: got %b want 1", kill);
    end
    tick();
    valid = 0; irq = 0;
    checks++;
    if (ctl !== 7'b11_011_11 || dpc !== 32'h204 || flush_pc !== 32'h800) begin
      errors++;
      $display("FAIL halt_entry: ctl=%b dpc=%h fpc=%h want 1101111/204/800", ctl, dpc, flush_pc);
    end
  endtask

  task automatic test_step;
    do_reset();
    step = 1; valid = 1; pc = 32'h300; npc = 32'h304;
    #1;
    checks++;
    if (kill !== 1'b0) begin
      errors++;
      $display("FAIL step_kill: got %b want 0", kill);
    end
    tick();
    valid = 0;
    checks++;
    if (ctl !== 7'b11_100_11 || dpc !== 32'h304) begin
      errors++;
      $display("FAIL step_entry: ctl=%b dpc=%h want 1110011/304", ctl, dpc);
    end
  endtask

  task automatic test_priority;
    do_reset();
    ebm = 1; ebreak = 1; irq = 1; step = 1; valid = 1; pc = 32'h400; npc = 32'h404;
    #1;
    checks++;
    if (kill !== 1'b1) begin
      errors++;
      $display("FAIL prio_kill: got %b want 1", kill);
    end
    tick();
    valid = 0; ebreak = 0; irq = 0; step = 0;
    checks++;
    if (ctl !== 7'b11_001_11 || dpc !== 32'h400) begin
      errors++;
      $display("FAIL prio_entry: ctl=%b dpc=%h want 1100111/400", ctl, dpc);
    end
  endtask

  task automatic test_dret_step;
    do_reset();
    step = 1; valid = 1; pc = 32'h300; npc = 32'h304;
    tick();
    valid = 0; ack = 1;
    tick();
    ack = 0; dmode = 1; dpc_r = 32'h304;
    valid = 1; irq = 1; pc = 32'h810; npc = 32'h814;
    #1;
    checks++;
    if (kill !== 1'b0) begin
      errors++;
      $display("FAIL dbg_ignore_kill: got %b want 0", kill);
    end
    tick();
    irq = 0; dret = 1;
    checks++;
    if (ctl !== 7'b00_100_00) begin
      errors++;
      $display("FAIL dbg_ignore: ctl=%b want 0010000", ctl);
    end
    tick();
    valid = 0; dret = 0; dpc_r = 32'h999;
    checks++;
    if (ctl !== 7'b01_000_11 || flush_pc !== 32'h304 || dpc !== 32'h304) begin
      errors++;
      $display("FAIL dret: ctl=%b fpc=%h dpc=%h want 0100011/304/304", ctl, flush_pc, dpc);
    end
    tick();
    checks++;
    if (ctl !== 7'b00_000_11 || flush_pc !== 32'h304) begin
      errors++;
      $display("FAIL dret_hold: ctl=%b fpc=%h want 0000011/304", ctl, flush_pc);
    end
    ack = 1;
    tick();
    ack = 0; dmode = 0;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL dret_ack: ctl=%b want 0000000", ctl);
    end
    valid = 1; pc = 32'h304; npc = 32'h308;
    #1;
    checks++;
    if (kill !== 1'b0) begin
      errors++;
      $display("FAIL restep_kill: got %b want 0", kill);
    end
    tick();
    valid = 0;
    checks++;
    if (ctl !== 7'b11_100_11 || dpc !== 32'h308 || flush_pc !== 32'h800) begin
      errors++;
      $display("FAIL restep: ctl=%b dpc=%h fpc=%h want 1110011/308/800", ctl, dpc, flush_pc);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    irq = 1; valid = 1; pc = 32'h600;
    tick();
    valid = 0; irq = 0;
    checks++;
    if (flush_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_req: got %b want 1", flush_req);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset: ctl=%b want 0000000", ctl);
    end
    ack = 1;
    tick();
    ack = 0;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL mid_late_ack: ctl=%b want 0000000", ctl);
    end
    irq = 1; valid = 1; pc = 32'h640;
    tick();
    valid = 0; irq = 0;
    checks++;
    if (ctl !== 7'b11_011_11 || dpc !== 32'h640) begin
      errors++;
      $display("FAIL mid_rerun: ctl=%b dpc=%h want 1101111/640", ctl, dpc);
    end
  endtask

  initial begin
    test_reset();
    test_ebreak();
    test_ebreak_disabled();
    test_haltreq();
    test_step();
    test_priority();
    test_dret_step();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
